uart_rx: RTL and testbench

//  Serial UART receiver: 8N1 frames (optional even parity) arrive on rx, LSB first.
//  - Runs its own bit timer from the same SYSTEM_CLOCK_FREQ/BAUD_RATE divider the TX side uses.
//  - Re-phases the timer on every start edge, so it does not depend on a free-running tick.
//  - Sits between the pad and the RX-side consumer; outputs one parallel byte per valid frame.

---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver whose bit timer is re-phased on every start edge.
// Define UART_PARITY_EN to add one even-parity bit between D7 and STOP.
module uart_rx #(
  parameter int SYSTEM_CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE         = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int          DIVIDER   = SYSTEM_CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST  = 16'(DIVIDER - 1);
  localparam logic [15:0] HALF_LAST = 16'(DIVIDER / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic        rx_meta, rx_s, rx_prev, fall;
  logic [15:0] counter_q, counter_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d, data_d;
  logic        valid_d, frame_err_d, parity_ok;

  // Synchronizer flops reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let this chain shift by one stage per clock; blocking would collapse it.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

`ifdef UART_PARITY_EN
  logic parity_q, parity_d, parity_err_d;

  assign parity_ok = ~(^{shift_q, parity_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_q   <= parity_d;
      parity_err <= parity_err_d;
    end
  end
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case leaves one unassigned (no latches).
    state_d     = state_q;
    counter_d   = counter_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    parity_d     = parity_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (counter_q == HALF_LAST) begin
          counter_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (counter_q == BIT_LAST) begin
          counter_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (counter_q == BIT_LAST) begin
          counter_d = '0;
          parity_d  = rx_s;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (counter_q == BIT_LAST) begin
          counter_d = '0;
          // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge.
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else if (parity_ok) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
`ifdef UART_PARITY_EN
            parity_err_d = 1'b1;
`endif
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        counter_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        counter_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx (DIVIDER=16): directed and random frames
// compared against a frame-level model of what each transmitted frame should produce.
module tb_uart_rx;
  localparam int DIV = 16;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int         checks = 0, failures = 0, cycle = 0;
  logic [7:0] got_data[$], exp_data[$];
  int         got_cyc[$];
  int         n_ferr = 0, n_perr = 0, exp_ferr = 0, exp_perr = 0, t_start = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_pulse = 1'b0;

  uart_rx #(.SYSTEM_CLOCK_FREQ(1600), .BAUD_RATE(100)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Pulse monitor: records every pulse and checks exclusivity / single-cycle width.
  always @(negedge clk) begin : monitor
    int n;
    n = int'(valid) + int'(frame_err) + int'(parity_err);
    if (n > 0) begin
      checks++;
      if (n > 1 || prev_pulse) begin
        failures++;
        $display("FAIL pulse_excl: valid=%b frame_err=%b parity_err=%b prev_pulse=%b, required one pulse lasting one cycle",
                 valid, frame_err, parity_err, prev_pulse);
      end
      if (valid) begin
        got_data.push_back(data);
        got_cyc.push_back(cycle);
      end
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
    end
    prev_pulse = (n > 0);
  end

  task automatic clear_obs();
    got_data.delete(); got_cyc.delete(); exp_data.delete();
    n_ferr = 0; n_perr = 0; exp_ferr = 0; exp_perr = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first 'limit' bits of a frame; only complete frames enter the model.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par, input int limit);
    logic fb[$];
    logic pbit;
    pbit = (^b) ^ bad_par;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(b[i]);
    if (PAR_EN) fb.push_back(pbit);
    fb.push_back(stop_bit);
    if (limit >= fb.size()) begin
      if (!stop_bit) exp_ferr++;
      else if (PAR_EN && ((^b) ^ pbit)) exp_perr++;
      else begin
        exp_data.push_back(b);
        last_good = b;
      end
    end
    t_start = cycle;
    for (int i = 0; i < fb.size() && i < limit; i++) begin
      rx = fb[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({data, valid, frame_err, parity_err, busy} !== 12'h000) begin
        failures++;
        $display("FAIL reset_outputs: data=%h valid=%b ferr=%b perr=%b busy=%b, required all 0",
                 data, valid, frame_err, parity_err, busy);
      end
    end
    rx = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2 * DIV);
    checks++;
    if (busy !== 1'b0 || got_data.size() != 0 || n_ferr != 0) begin
      failures++;
      $display("FAIL reset_no_frame: busy=%b valids=%0d ferr=%0d, required 0/0/0", busy, got_data.size(), n_ferr);
    end
  endtask

  task automatic test_single();
    clear_obs();
    send_frame(8'hA5, 1'b1, 1'b0, 99);
    idle(2 * DIV);
    checks++;
    if (got_data.size() != 1 || data !== 8'hA5) begin
      failures++;
      $display("FAIL single_a5: valids=%0d data=%h, required 1 and a5", got_data.size(), data);
    end
    checks++;
    if (got_cyc.size() == 1 && (got_cyc[0] - t_start < 150 || got_cyc[0] - t_start > 160)) begin
      failures++;
      $display("FAIL single_latency: %0d clk, required 150..160", got_cyc[0] - t_start);
    end
    checks++;
    if (n_ferr != 0 || n_perr != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_flags: ferr=%0d perr=%0d busy=%b, required 0/0/0", n_ferr, n_perr, busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h00, 1'b1, 1'b0, 99);
    send_frame(8'hFF, 1'b1, 1'b0, 99);
    idle(2 * DIV);
    checks++;
    if (got_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d valids, required %0d", got_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        checks++;
        if (got_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got %h required %h", i, got_data[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit saw_busy;
    int idle_at;
    clear_obs();
    saw_busy = 1'b0;
    idle_at  = -1;
    rx = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (i == 5) rx = 1'b1;
      if (busy) saw_busy = 1'b1;
      else if (saw_busy && idle_at < 0) idle_at = i;
    end
    checks++;
    if (!saw_busy || idle_at < 10 || idle_at > 12) begin
      failures++;
      $display("FAIL glitch_busy: saw_busy=%b idle_at=%0d, required 1 and 10..12", saw_busy, idle_at);
    end
    checks++;
    if (got_data.size() != 0 || n_ferr != 0 || n_perr != 0) begin
      failures++;
      $display("FAIL glitch_pulses: valids=%0d ferr=%0d perr=%0d, required none", got_data.size(), n_ferr, n_perr);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] prior;
    clear_obs();
    prior = last_good;
    send_frame(8'h3C, 1'b0, 1'b0, 99);
    rx = 1'b0;
    repeat (40 - DIV) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL break_busy: busy=%b while line low, required 1", busy);
    end
    idle(DIV);
    checks++;
    if (n_ferr != exp_ferr || got_data.size() != 0 || data !== prior) begin
      failures++;
      $display("FAIL frame_err: ferr=%0d valids=%0d data=%h, required %0d/0/%h", n_ferr, got_data.size(), data, exp_ferr, prior);
    end
    send_frame(8'h81, 1'b1, 1'b0, 99);
    idle(2 * DIV);
    checks++;
    if (got_data.size() != 1 || data !== 8'h81) begin
      failures++;
      $display("FAIL after_break: valids=%0d data=%h, required 1 and 81", got_data.size(), data);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    clear_obs();
    send_frame(8'h07, 1'b1, 1'b0, 99);
    idle(DIV);
    checks++;
    if (got_data.size() != 1 || data !== 8'h07 || n_perr != 0) begin
      failures++;
      $display("FAIL parity_good: valids=%0d data=%h perr=%0d, required 1/07/0", got_data.size(), data, n_perr);
    end
    send_frame(8'h07, 1'b1, 1'b1, 99);
    idle(DIV);
    checks++;
    if (got_data.size() != 1 || n_perr != 1) begin
      failures++;
      $display("FAIL parity_bad: valids=%0d perr=%0d, required 1/1", got_data.size(), n_perr);
    end
  endtask
`endif

  task automatic test_reset_mid();
    clear_obs();
    send_frame(8'h5A, 1'b1, 1'b0, 5);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_busy: busy=%b during rst, required 0", busy);
      end
    end
    rx  = 1'b1;
    rst = 1'b0;
    idle(DIV);
    checks++;
    if (got_data.size() != 0 || n_ferr != 0 || n_perr != 0) begin
      failures++;
      $display("FAIL rst_mid_pulses: valids=%0d ferr=%0d perr=%0d, required none", got_data.size(), n_ferr, n_perr);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 99);
    idle(2 * DIV);
    checks++;
    if (got_data.size() != 1 || data !== 8'h5A) begin
      failures++;
      $display("FAIL rst_mid_next: valids=%0d data=%h, required 1 and 5a", got_data.size(), data);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop_bit, bad;
    clear_obs();
    for (int n = 0; n < 16; n++) begin
      b        = 8'($urandom);
      stop_bit = ($urandom_range(0, 7) != 0);
      bad      = PAR_EN && ($urandom_range(0, 5) == 0);
      send_frame(b, stop_bit, bad, 99);
      idle(stop_bit ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12)));
    end
    idle(2 * DIV);
    checks++;
    if (n_ferr != exp_ferr || n_perr != exp_perr) begin
      failures++;
      $display("FAIL random_errs: ferr=%0d perr=%0d, required %0d/%0d", n_ferr, n_perr, exp_ferr, exp_perr);
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL random_count: got %0d valids, required %0d", got_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        checks++;
        if (got_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL random_data[%0d]: got %h required %h", i, got_data[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
